// File: rtl/yuv_to_rgb_core.sv
// Three-stage BT.601 full-range YCbCr -> RGB converter with Q8 coefficients.
// One pixel may enter per clock; pixel_ready marks each result.
module yuv_to_rgb_core (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_conversion,
   input  logic [7:0] y,
   input  logic [7:0] u,
   input  logic [7:0] v,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic       pixel_ready
);

   localparam logic signed [19:0] KRV = 20'sd359;
   localparam logic signed [19:0] KGU = 20'sd88;
   localparam logic signed [19:0] KGV = 20'sd183;
   localparam logic signed [19:0] KBU = 20'sd454;

   // Add half an LSB, then floor-shift out the Q8 fraction.
   function automatic logic signed [19:0] round_q8(input logic signed [19:0] x);
      return (x + 20'sd128) >>> 8;
   endfunction

   function automatic logic [7:0] sat_u8(input logic signed [19:0] x);
      if (x < 20'sd0)
         return 8'h00;
      else if (x > 20'sd255)
         return 8'hFF;
      else
         return x[7:0];
   endfunction

   logic                vld_p1_q, vld_p2_q, vld_p3_q;
   logic [7:0]          y_p1_q, y_p2_q;
   logic signed [8:0]   du_p1_d, dv_p1_d, du_p1_q, dv_p1_q;
   logic signed [19:0]  du_w, dv_w;
   logic signed [19:0]  prv_p2_d, pgu_p2_d, pgv_p2_d, pbu_p2_d;
   logic signed [19:0]  prv_p2_q, pgu_p2_q, pgv_p2_q, pbu_p2_q;
   logic signed [19:0]  y_s, r_s, g_s, b_s;
   logic [7:0]          r_p3_d, g_p3_d, b_p3_d;
   logic [7:0]          r_p3_q, g_p3_q, b_p3_q;

   always_comb begin
      du_p1_d  = signed'({1'b0, u}) - 9'sd128;
      dv_p1_d  = signed'({1'b0, v}) - 9'sd128;
      du_w     = signed'({{11{du_p1_q[8]}}, du_p1_q});
      dv_w     = signed'({{11{dv_p1_q[8]}}, dv_p1_q});
      prv_p2_d = KRV * dv_w;
      pgu_p2_d = KGU * du_w;
      pgv_p2_d = KGV * dv_w;
      pbu_p2_d = KBU * du_w;
      y_s      = signed'({12'd0, y_p2_q});
      r_s      = y_s + round_q8(prv_p2_q);
      g_s      = y_s + round_q8(-pgu_p2_q - pgv_p2_q);
      b_s      = y_s + round_q8(pbu_p2_q);
      r_p3_d   = sat_u8(r_s);
      g_p3_d   = sat_u8(g_s);
      b_p3_d   = sat_u8(b_s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         y_p1_q   <= '0;
         du_p1_q  <= '0;
         dv_p1_q  <= '0;
         y_p2_q   <= '0;
         prv_p2_q <= '0;
         pgu_p2_q <= '0;
         pgv_p2_q <= '0;
         pbu_p2_q <= '0;
         r_p3_q   <= '0;
         g_p3_q   <= '0;
         b_p3_q   <= '0;
      end else begin
         // Stage 1: capture luma and centred chroma
         vld_p1_q <= start_conversion;
         if (start_conversion) begin
            y_p1_q  <= y;
            du_p1_q <= du_p1_d;
            dv_p1_q <= dv_p1_d;
         end
         // Stage 2: coefficient products
         vld_p2_q <= vld_p1_q;
         if (vld_p1_q) begin
            y_p2_q   <= y_p1_q;
            prv_p2_q <= prv_p2_d;
            pgu_p2_q <= pgu_p2_d;
            pgv_p2_q <= pgv_p2_d;
            pbu_p2_q <= pbu_p2_d;
         end
         // Stage 3: sum, round, clamp; outputs hold between results
         vld_p3_q <= vld_p2_q;
         if (vld_p2_q) begin
            r_p3_q <= r_p3_d;
            g_p3_q <= g_p3_d;
            b_p3_q <= b_p3_d;
         end
      end
   end

   assign r           = r_p3_q;
   assign g           = g_p3_q;
   assign b           = b_p3_q;
   assign pixel_ready = vld_p3_q;

endmodule

// File: tb/tb_yuv_to_rgb_core.sv
// Directed bench for yuv_to_rgb_core: reset, conversion vectors, saturation,
// holding behaviour and back-to-back / gapped issue.
module tb_yuv_to_rgb_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_conversion = 1'b0;
   logic [7:0] y = 8'h00, u = 8'h00, v = 8'h00;
   logic [7:0] r, g, b;
   logic       pixel_ready;

   int n_cmp = 0;
   int n_bad = 0;

   yuv_to_rgb_core dut (
      .clk(clk), .rst_n(rst_n), .start_conversion(start_conversion),
      .y(y), .u(u), .v(v), .r(r), .g(g), .b(b), .pixel_ready(pixel_ready)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic s, input logic [7:0] yy, uu, vv);
      @(negedge clk);
      start_conversion = s;
      y = yy; u = uu; v = vv;
   endtask

   task automatic test_reset();
      logic [24:0] got;
      rst_n = 1'b0;
      #2;
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== 25'h0) begin
         $display("FAIL reset_initial: got %h required %h", got, 25'h0); n_bad++;
      end
      @(negedge clk); rst_n = 1'b1;
      // Produce a nonzero result first so reset clearing is visible.
      drive(1'b1, 8'hFF, 8'hFF, 8'hFF);
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk); @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b1, 8'hFF, 8'h79, 8'hFF}) begin
         $display("FAIL reset_preload: got %h required %h", got, {1'b1, 8'hFF, 8'h79, 8'hFF}); n_bad++;
      end
      // Start, then assert reset asynchronously in the middle of the next cycle.
      drive(1'b1, 8'h64, 8'h80, 8'hC8);
      @(posedge clk); #2;
      start_conversion = 1'b0;
      rst_n = 1'b0;
      #1;
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== 25'h0) begin
         $display("FAIL reset_async: got %h required %h", got, 25'h0); n_bad++;
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         got = {pixel_ready, r, g, b};
         n_cmp++;
         if (got !== 25'h0) begin
            $display("FAIL reset_discard[%0d]: got %h required %h", i, got, 25'h0); n_bad++;
         end
      end
   endtask

   // Single start, check the pulse and that outputs hold afterwards while
   // y/u/v carry junk without a start.
   task automatic test_vector(input string name, input logic [7:0] yy, uu, vv,
                              input logic [7:0] er, eg, eb);
      logic [24:0] got;
      drive(1'b1, yy, uu, vv);
      drive(1'b0, 8'hA5, 8'h3C, 8'hE1);
      @(negedge clk);
      n_cmp++;
      if (pixel_ready !== 1'b0) begin
         $display("FAIL %s_early: got %b required 0", name, pixel_ready); n_bad++;
      end
      y = 8'h00; u = 8'hFF; v = 8'h00;
      @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b1, er, eg, eb}) begin
         $display("FAIL %s_result: got %h required %h", name, got, {1'b1, er, eg, eb}); n_bad++;
      end
      for (int i = 0; i < 2; i++) begin
         y = 8'($urandom); u = 8'($urandom); v = 8'($urandom);
         @(negedge clk);
         got = {pixel_ready, r, g, b};
         n_cmp++;
         if (got !== {1'b0, er, eg, eb}) begin
            $display("FAIL %s_hold[%0d]: got %h required %h", name, i, got, {1'b0, er, eg, eb}); n_bad++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [24:0] got;
      drive(1'b1, 8'hFF, 8'hFF, 8'hFF);
      drive(1'b1, 8'h64, 8'h80, 8'hC8);
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b1, 8'hFF, 8'h79, 8'hFF}) begin
         $display("FAIL b2b_first: got %h required %h", got, {1'b1, 8'hFF, 8'h79, 8'hFF}); n_bad++;
      end
      @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b1, 8'hC9, 8'h31, 8'h64}) begin
         $display("FAIL b2b_second: got %h required %h", got, {1'b1, 8'hC9, 8'h31, 8'h64}); n_bad++;
      end
      @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b0, 8'hC9, 8'h31, 8'h64}) begin
         $display("FAIL b2b_after: got %h required %h", got, {1'b0, 8'hC9, 8'h31, 8'h64}); n_bad++;
      end
   endtask

   task automatic test_gap();
      logic [24:0] got;
      drive(1'b1, 8'h22, 8'h15, 8'h12);
      drive(1'b0, 8'h80, 8'h80, 8'h80);
      drive(1'b1, 8'h80, 8'h80, 8'h80);
      drive(1'b0, 8'h00, 8'h00, 8'h00);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b1, 8'h00, 8'h95, 8'h00}) begin
         $display("FAIL gap_first: got %h required %h", got, {1'b1, 8'h00, 8'h95, 8'h00}); n_bad++;
      end
      @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b0, 8'h00, 8'h95, 8'h00}) begin
         $display("FAIL gap_hole: got %h required %h", got, {1'b0, 8'h00, 8'h95, 8'h00}); n_bad++;
      end
      @(negedge clk);
      got = {pixel_ready, r, g, b};
      n_cmp++;
      if (got !== {1'b1, 8'h80, 8'h80, 8'h80}) begin
         $display("FAIL gap_second: got %h required %h", got, {1'b1, 8'h80, 8'h80, 8'h80}); n_bad++;
      end
      @(negedge clk);
      n_cmp++;
      if (pixel_ready !== 1'b0) begin
         $display("FAIL gap_end: got %b required 0", pixel_ready); n_bad++;
      end
   endtask

   initial begin
      test_reset();
      test_vector("clamp_low", 8'h22, 8'h15, 8'h12, 8'h00, 8'h95, 8'h00);
      test_vector("grey",      8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
      test_vector("black",     8'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00);
      test_vector("clamp_hi",  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h79, 8'hFF);
      test_vector("red_bias",  8'h64, 8'h80, 8'hC8, 8'hC9, 8'h31, 8'h64);
      test_back_to_back();
      test_gap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
